// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing presets, bar colours and size helpers
// Purpose: common constants and functions for the VGA timing engine files.
// Ports: none (package).
package vga_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
   } timing_t;

   localparam timing_t VGA_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33};
   localparam timing_t VGA_800X600_60 = '{800, 40, 128, 88, 600, 1, 4, 23};

   // Colour bars, {r,g,b} three bits each, written in octal so each digit is one channel.
   localparam logic [8:0] BAR_WHITE   = 9'o777;
   localparam logic [8:0] BAR_YELLOW  = 9'o770;
   localparam logic [8:0] BAR_CYAN    = 9'o077;
   localparam logic [8:0] BAR_GREEN   = 9'o070;
   localparam logic [8:0] BAR_MAGENTA = 9'o707;
   localparam logic [8:0] BAR_RED     = 9'o700;
   localparam logic [8:0] BAR_BLUE    = 9'o007;
   localparam logic [8:0] BAR_BLACK   = 9'o000;

   function automatic int line_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic logic [8:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = BAR_WHITE;
         3'd1:    bar_color = BAR_YELLOW;
         3'd2:    bar_color = BAR_CYAN;
         3'd3:    bar_color = BAR_GREEN;
         3'd4:    bar_color = BAR_MAGENTA;
         3'd5:    bar_color = BAR_RED;
         3'd6:    bar_color = BAR_BLUE;
         default: bar_color = BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// rtl/vga_timing_engine_if.sv - renderer/pin-side signal bundle of the VGA timing engine
// Purpose: groups control, renderer colour and all timing outputs.
// Ports (master = engine):
//   in : en, test_mode, rgb_in[8:0]
//   out: x, y [CW-1:0], pix_tick, line_start, frame_start, frame_cnt[15:0],
//        hs, vs, de, r, g, b [2:0]
interface vga_timing_engine_if #(parameter int CW = 11);
   logic          en;
   logic          test_mode;
   logic [8:0]    rgb_in;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          pix_tick;
   logic          line_start;
   logic          frame_start;
   logic [15:0]   frame_cnt;
   logic          hs;
   logic          vs;
   logic          de;
   logic [2:0]    r;
   logic [2:0]    g;
   logic [2:0]    b;

   modport master (
      input  en, test_mode, rgb_in,
      output x, y, pix_tick, line_start, frame_start, frame_cnt, hs, vs, de, r, g, b
   );

   modport slave (
      output en, test_mode, rgb_in,
      input  x, y, pix_tick, line_start, frame_start, frame_cnt, hs, vs, de, r, g, b
   );
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - DEPTH-stage shift-on-enable register chain
// Purpose: delays decoded timing flags (and bar index) by the renderer latency.
// Ports:
//   clk, rst  clock, synchronous active-high reset (stages clear to zero = inactive)
//   shift     advance the chain by one stage
//   d         entry into stage 0
//   tap       value that the next shift loads into the last stage
//   q         last stage
module vga_delay_line #(
   parameter int W     = 3,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic [W-1:0] tap,
   output logic [W-1:0] q
);
   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (shift) begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   // The colour register is loaded on the same shift as the last stage, so it
   // gates with the value about to land there rather than the one leaving.
   if (DEPTH == 1) begin : g_tap_in
      assign tap = d;
   end else begin : g_tap_stage
      assign tap = stage[DEPTH-2];
   end

   assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_timing_engine.sv
// rtl/vga_timing_engine.sv - parametrised VGA sync/enable/coordinate generator
// Purpose: divides clk to a pixel tick, scans h/v counters, decodes active and
//   sync regions, delays them by the renderer latency and gates colour to black.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  vga_timing_engine_if.master: en, test_mode, rgb_in in;
//        x, y, pix_tick, line_start, frame_start, frame_cnt, hs, vs, de, r, g, b out
// Build option: VGA_TESTPAT_EN adds colour bars selected by test_mode.
module vga_timing_engine
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int PIPE     = 1,
   parameter int CW       = 11
) (
   input logic                clk,
   input logic                rst,
   vga_timing_engine_if.master bus
);
   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0]    H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0]    V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0]    HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0]    HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0]    VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0]    VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div;
   logic [CW-1:0]    h;
   logic [CW-1:0]    v;
   logic [15:0]      frames;
   logic             tick;
   logic             act;
   logic             hs_a;
   logic             vs_a;
   logic [8:0]       colour;
   logic [8:0]       rgb_q;
   logic             unused_bits;

`ifdef VGA_TESTPAT_EN
   localparam int ENT_W = 6;
   logic [CW+2:0] h_x8;
   logic [2:0]    bar;
   assign h_x8 = {h, 3'b000};
   // Out-of-range values outside the active area are harmless: de gates them.
   assign bar  = 3'(h_x8 / (CW+3)'(H_ACTIVE));
`else
   localparam int ENT_W = 3;
`endif

   logic [ENT_W-1:0] ent;
   logic [ENT_W-1:0] tap;
   logic [ENT_W-1:0] q;

   assign tick = bus.en && (div == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         div    <= '0;
         h      <= '0;
         v      <= '0;
         frames <= '0;
      end else if (bus.en) begin
         div <= (div == DIV_LAST) ? '0 : div + 1'b1;
         if (tick) begin
            if (h == H_LAST) begin
               h <= '0;
               if (v == V_LAST) begin
                  v      <= '0;
                  frames <= frames + 16'd1;
               end else begin
                  v <= v + 1'b1;
               end
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   assign act  = (h < H_ACT) && (v < V_ACT);
   assign hs_a = (h >= HS_START) && (h < HS_END);
   assign vs_a = (v >= VS_START) && (v < VS_END);

`ifdef VGA_TESTPAT_EN
   assign ent         = {bar, act, hs_a, vs_a};
   assign colour      = bus.test_mode ? bar_color(tap[5:3]) : bus.rgb_in;
   assign unused_bits = ^{tap[1:0], q[ENT_W-1:3]};
`else
   assign ent         = {act, hs_a, vs_a};
   assign colour      = bus.rgb_in;
   assign unused_bits = ^{tap[1:0], bus.test_mode};
`endif

   vga_delay_line #(.W(ENT_W), .DEPTH(PIPE)) u_delay (
      .clk   (clk),
      .rst   (rst),
      .shift (tick),
      .d     (ent),
      .tap   (tap),
      .q     (q)
   );

   always_ff @(posedge clk) begin
      if (rst)       rgb_q <= '0;
      else if (tick) rgb_q <= tap[2] ? colour : 9'd0;
   end

   assign bus.x           = h;
   assign bus.y           = v;
   assign bus.pix_tick    = tick;
   assign bus.line_start  = tick && (h == '0);
   assign bus.frame_start = tick && (h == '0) && (v == '0);
   assign bus.frame_cnt   = frames;
   assign bus.hs          = q[1] ? HS_POL : ~HS_POL;
   assign bus.vs          = q[0] ? VS_POL : ~VS_POL;
   assign bus.de          = q[2];
   assign bus.r           = rgb_q[8:6];
   assign bus.g           = rgb_q[5:3];
   assign bus.b           = rgb_q[2:0];
endmodule

// File: tb/tb_vga_timing_engine.sv
// tb/tb_vga_timing_engine.sv - directed self-checking bench for vga_timing_engine
// Purpose: small 14x7 raster, CLK_DIV=2, PIPE=1; checks reset, line, frame, en hold,
//   colour gating, test pattern (when VGA_TESTPAT_EN is defined) and mid-line reset.
// Ports: none.
module tb_vga_timing_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int t_fs0;
   int vs_low;
   int fx;
   int fy;
   int n;
   logic [13:0] de_tab;
   logic [13:0] hs_tab;
   logic [8:0]  pat_exp;

   vga_timing_engine_if #(.CW(11)) bus ();

   vga_timing_engine #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .PIPE(1), .CW(11)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wait_tick();
      int k = 0;
      do begin
         step(1);
         k++;
      end while (!bus.pix_tick && k < 8);
      check("tick_seen", int'(bus.pix_tick), 1);
   endtask

   task automatic wait_x(input int tx);
      int k = 0;
      do begin
         wait_tick();
         k++;
      end while (int'(bus.x) != tx && k < 20);
      check("wait_x", int'(bus.x), tx);
   endtask

   initial begin
      // de/hs seen at a tick with x=k describe pixel k-1
      de_tab = 14'h01FE;
      hs_tab = 14'h27FF;
      bus.en        = 1'b1;
      bus.test_mode = 1'b0;
      bus.rgb_in    = 9'h1FF;

      step(2);
      check("rst_x",     int'(bus.x), 0);
      check("rst_y",     int'(bus.y), 0);
      check("rst_tick",  int'(bus.pix_tick), 0);
      check("rst_fs",    int'(bus.frame_start), 0);
      check("rst_hs",    int'(bus.hs), 1);
      check("rst_vs",    int'(bus.vs), 1);
      check("rst_de",    int'(bus.de), 0);
      check("rst_rgb",   int'({bus.r, bus.g, bus.b}), 0);
      check("rst_fcnt",  int'(bus.frame_cnt), 0);

      rst = 1'b0;
      step(1);
      t_fs0 = cyc;
      check("first_tick", int'(bus.pix_tick), 1);
      check("first_fs",   int'(bus.frame_start), 1);
      check("first_ls",   int'(bus.line_start), 1);
      check("first_y",    int'(bus.y), 0);
      check("first_vs",   int'(bus.vs), 1);

      for (int k = 0; k < 14; k++) begin
         check("line_x",   int'(bus.x), k);
         check("line_de",  int'(bus.de), int'(de_tab[k]));
         check("line_hs",  int'(bus.hs), int'(hs_tab[k]));
         check("line_rgb", int'({bus.r, bus.g, bus.b}), de_tab[k] ? 9'h1FF : 0);
         wait_tick();
      end
      check("ls_next",    int'(bus.line_start), 1);
      check("ls_not_fs",  int'(bus.frame_start), 0);
      check("ls_y",       int'(bus.y), 1);
      check("ls_period",  cyc - t_fs0, 28);

      vs_low = 0;
      fx = -1;
      fy = -1;
      n = 0;
      while (!bus.frame_start && n < 120) begin
         if (!bus.vs) begin
            if (vs_low == 0) begin
               fx = int'(bus.x);
               fy = int'(bus.y);
            end
            vs_low++;
         end
         wait_tick();
         n++;
      end
      check("fs_seen",    int'(bus.frame_start), 1);
      check("fs_period",  cyc - t_fs0, 196);
      check("fcnt_1",     int'(bus.frame_cnt), 1);
      check("vs_ticks",   vs_low, 14);
      check("vs_first_x", fx, 1);
      check("vs_first_y", fy, 5);

      wait_x(3);
      bus.en = 1'b0;
      #1;
      check("en0_tick", int'(bus.pix_tick), 0);
      repeat (10) begin
         step(1);
         check("hold_x",    int'(bus.x), 3);
         check("hold_tick", int'(bus.pix_tick), 0);
         check("hold_ls",   int'(bus.line_start), 0);
      end
      check("hold_de",  int'(bus.de), 1);
      check("hold_rgb", int'({bus.r, bus.g, bus.b}), 9'h1FF);
      bus.en = 1'b1;
      #1;
      check("resume_tick", int'(bus.pix_tick), 1);
      check("resume_x0",   int'(bus.x), 3);
      wait_tick();
      check("resume_x1",   int'(bus.x), 4);

      bus.test_mode = 1'b1;
      bus.rgb_in    = 9'h159;
`ifdef VGA_TESTPAT_EN
      pat_exp = 9'o707;
`else
      pat_exp = 9'h159;
`endif
      wait_tick();
      check("pat_x4", int'({bus.r, bus.g, bus.b}), int'(pat_exp));
`ifdef VGA_TESTPAT_EN
      pat_exp = 9'o700;
`endif
      wait_tick();
      check("pat_x5", int'({bus.r, bus.g, bus.b}), int'(pat_exp));
      wait_x(10);
      check("pat_blank_rgb", int'({bus.r, bus.g, bus.b}), 0);
      check("pat_blank_de",  int'(bus.de), 0);
`ifdef VGA_TESTPAT_EN
      pat_exp = 9'o777;
`endif
      wait_x(1);
      check("pat_x0", int'({bus.r, bus.g, bus.b}), int'(pat_exp));
      check("pat_de", int'(bus.de), 1);

      rst = 1'b1;
      step(1);
      check("mrst_x",    int'(bus.x), 0);
      check("mrst_y",    int'(bus.y), 0);
      check("mrst_tick", int'(bus.pix_tick), 0);
      check("mrst_ls",   int'(bus.line_start), 0);
      check("mrst_hs",   int'(bus.hs), 1);
      check("mrst_vs",   int'(bus.vs), 1);
      check("mrst_de",   int'(bus.de), 0);
      check("mrst_rgb",  int'({bus.r, bus.g, bus.b}), 0);
      check("mrst_fcnt", int'(bus.frame_cnt), 0);
      rst = 1'b0;
      bus.test_mode = 1'b0;
      step(1);
      check("rerun_tick", int'(bus.pix_tick), 1);
      check("rerun_fs",   int'(bus.frame_start), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
